// File: rtl/pi_fifo_gen.sv
// pi_fifo_gen: strobe-driven single-clock mailbox FIFO (next generation of the PI bus <-> 68k
// register window FIFO). All state changes on the falling edge of clk.
//
// Ports:
//   clk          system clock (falling edge active)
//   sys_rst_n    asynchronous active-low reset
//   wr_req/din   write strobe (level) and data; entry is committed when the strobe is released
//   rd_req       read strobe (level); head entry is popped when the strobe is released
//   dout         registered head-of-queue data
//   flush        one-cycle pulse: discard all stored entries
//   clr_err      one-cycle pulse: clear the sticky overflow/underflow flags
//   empty/full/almost_full/level   registered occupancy status
//   overflow/underflow             sticky error flags for rejected commits
module pi_fifo_gen #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 11,
    parameter int unsigned AF_THRESH = (2 ** AW) - 16
) (
    input  logic          clk,
    input  logic          sys_rst_n,
    input  logic          wr_req,
    input  logic [DW-1:0] din,
    input  logic          rd_req,
    output logic [DW-1:0] dout,
    input  logic          flush,
    input  logic          clr_err,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow
);

    localparam int unsigned Depth    = 2 ** AW;
    localparam logic [AW:0] AfThresh = AF_THRESH[AW:0];
    localparam logic [AW:0] PtrOne   = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem_q [Depth];

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]    wr_hist_q, wr_hist_d;
    logic [1:0]    rd_hist_q, rd_hist_d;
    logic [DW-1:0] dout_q;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic wr_commit, rd_commit, wr_accept, rd_accept;

    always_comb begin
        wr_hist_d = {wr_hist_q[0], wr_req};
        rd_hist_d = {rd_hist_q[0], rd_req};

        // A commit is the edge after the strobe was first seen low following a high sample.
        wr_commit = (wr_hist_q == 2'b10);
        rd_commit = (rd_hist_q == 2'b10);

        // Acceptance uses the status held before this edge's pointer updates.
        wr_accept = wr_commit && !full_q;
        rd_accept = rd_commit && !empty_q && !flush;

        wr_ptr_d = wr_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end

        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        level_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        af_d    = (level_d >= AfThresh);

        // A new error on the same edge as clr_err keeps the flag set.
        overflow_d  = (overflow_q && !clr_err) || (wr_commit && full_q);
        underflow_d = (underflow_q && !clr_err) || (rd_commit && empty_q);
    end

    // Storage has no reset; the last high sample of the strobe leaves its data in place.
    always_ff @(negedge clk) begin
        if (wr_req && !full_q) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(negedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_hist_q   <= 2'b00;
            rd_hist_q   <= 2'b00;
            dout_q      <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_hist_q   <= wr_hist_d;
            rd_hist_q   <= rd_hist_d;
            // Head data follows rd_ptr with one edge of latency.
            dout_q      <= mem_q[rd_ptr_q[AW-1:0]];
            empty_q     <= empty_d;
            full_q      <= full_d;
            af_q        <= af_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign dout        = dout_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_pi_fifo_gen.sv
module tb_pi_fifo_gen;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;

    localparam int OpW  = 0;  // write
    localparam int OpR  = 1;  // read
    localparam int OpB  = 2;  // write and read committing together
    localparam int OpFW = 3;  // flush with same-edge write commit
    localparam int OpF  = 4;  // flush only
    localparam int OpC  = 5;  // clr_err

    logic          clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          wr_req = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd_req = 1'b0;
    logic [DW-1:0] dout;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic          empty, full, almost_full;
    logic [AW:0]   level;
    logic          overflow, underflow;

    pi_fifo_gen #(
        .DW       (DW),
        .AW       (AW),
        .AF_THRESH(AF)
    ) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .wr_req     (wr_req),
        .din        (din),
        .rd_req     (rd_req),
        .dout       (dout),
        .flush      (flush),
        .clr_err    (clr_err),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .level      (level),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: plain queue plus sticky flags.
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    typedef struct {
        int         op;
        logic [7:0] d;
        int         lvl;
        bit         emp;
        bit         ful;
        bit         af;
        bit         ovf;
        bit         unf;
        bit         chk_dout;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[12];

    int         k;
    logic [7:0] rd8;
    logic [7:0] pat;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".level"}, int'(level), m_q.size());
        chk({tag, ".empty"}, int'(empty), int'(m_q.size() == 0));
        chk({tag, ".full"}, int'(full), int'(m_q.size() == DEPTH));
        chk({tag, ".almost_full"}, int'(almost_full), int'(m_q.size() >= AF));
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(m_unf));
        if (m_q.size() > 0) chk({tag, ".dout"}, int'(dout), int'(m_q[0]));
    endtask

    task automatic model_op(input bit w, input bit r, input logic [7:0] d, input bit fl);
        int pre;
        pre = m_q.size();
        if (r && pre == 0) m_unf = 1'b1;
        else if (r && !fl) void'(m_q.pop_front());
        if (fl) m_q.delete();
        if (w) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(d);
        end
    endtask

    // One strobe cycle: high for one sample, commit two edges later, flush aligned to the commit.
    task automatic strobe(input bit w, input bit r, input logic [7:0] d, input bit fl);
        @(posedge clk);
        wr_req = w;
        rd_req = r;
        din    = d;
        @(posedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(posedge clk);
        flush = fl;
        @(posedge clk);
        flush = 1'b0;
        @(posedge clk);
        model_op(w, r, d, fl);
    endtask

    task automatic do_clr();
        @(posedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        clr_err = 1'b0;
        @(posedge clk);
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic do_op(input int op, input logic [7:0] d);
        case (op)
            OpW:  strobe(1'b1, 1'b0, d, 1'b0);
            OpR:  strobe(1'b0, 1'b1, d, 1'b0);
            OpB:  strobe(1'b1, 1'b1, d, 1'b0);
            OpFW: strobe(1'b1, 1'b0, d, 1'b1);
            OpF:  strobe(1'b0, 1'b0, d, 1'b1);
            default: do_clr();
        endcase
    endtask

    task automatic empty_out();
        strobe(1'b0, 1'b0, 8'h00, 1'b1);
        do_clr();
    endtask

    initial begin
        //          op    d      lvl emp ful af ovf unf cd dout
        vecs[0]  = '{OpW,  8'h11, 1, 0, 0, 0, 0, 0, 1, 8'h11};
        vecs[1]  = '{OpW,  8'h22, 2, 0, 0, 0, 0, 0, 1, 8'h11};
        vecs[2]  = '{OpW,  8'h33, 3, 0, 0, 0, 0, 0, 1, 8'h11};
        vecs[3]  = '{OpR,  8'h00, 2, 0, 0, 0, 0, 0, 1, 8'h22};
        vecs[4]  = '{OpR,  8'h00, 1, 0, 0, 0, 0, 0, 1, 8'h33};
        vecs[5]  = '{OpR,  8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[6]  = '{OpR,  8'h00, 0, 1, 0, 0, 0, 1, 0, 8'h00};
        vecs[7]  = '{OpC,  8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[8]  = '{OpW,  8'h44, 1, 0, 0, 0, 0, 0, 1, 8'h44};
        vecs[9]  = '{OpB,  8'h55, 1, 0, 0, 0, 0, 0, 1, 8'h55};
        vecs[10] = '{OpFW, 8'h66, 1, 0, 0, 0, 0, 0, 1, 8'h66};
        vecs[11] = '{OpF,  8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00};

        repeat (3) @(posedge clk);
        chk("reset.level", int'(level), 0);
        chk("reset.empty", int'(empty), 1);
        chk("reset.full", int'(full), 0);
        chk("reset.almost_full", int'(almost_full), 0);
        chk("reset.overflow", int'(overflow), 0);
        chk("reset.underflow", int'(underflow), 0);
        chk("reset.dout", int'(dout), 0);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed table with hand-derived expectations.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].d);
            chk($sformatf("vec%0d.level", i), int'(level), vecs[i].lvl);
            chk($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].emp));
            chk($sformatf("vec%0d.full", i), int'(full), int'(vecs[i].ful));
            chk($sformatf("vec%0d.almost_full", i), int'(almost_full), int'(vecs[i].af));
            chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].ovf));
            chk($sformatf("vec%0d.underflow", i), int'(underflow), int'(vecs[i].unf));
            if (vecs[i].chk_dout) chk($sformatf("vec%0d.dout", i), int'(dout), int'(vecs[i].dout));
        end

        // Fill past full: almost_full at 12, full at 16, 17th write overflows.
        for (int i = 0; i < 17; i++) begin
            strobe(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
            check_model($sformatf("fill%0d", i));
        end
        do_clr();
        check_model("fill.clr");

        // Simultaneous commits at full: write rejected, read pops.
        strobe(1'b1, 1'b1, 8'hEE, 1'b0);
        check_model("both_full");
        chk("both_full.level15", int'(level), 15);
        empty_out();
        check_model("flushed");

        // Simultaneous commits at empty: read rejected, write pushes.
        strobe(1'b1, 1'b1, 8'h3C, 1'b0);
        check_model("both_empty");
        chk("both_empty.underflow", int'(underflow), 1);
        empty_out();

        // Level 5 then flush with a same-edge write of 0xA5.
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 8'(i + 1), 1'b0);
        check_model("lvl5");
        strobe(1'b1, 1'b0, 8'hA5, 1'b1);
        check_model("flush_write");
        chk("flush_write.dout", int'(dout), 8'hA5);
        empty_out();

        // Alternating write/read, enough to wrap the pointers several times.
        pat = 8'h00;
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 40; i++) begin
                strobe(1'b1, 1'b0, pat, 1'b0);
                chk("wrap.dout", int'(dout), int'(pat));
                strobe(1'b0, 1'b1, 8'h00, 1'b0);
                pat = pat + 8'h01;
            end
            check_model($sformatf("wrap_round%0d", round));
        end
        chk("wrap.empty_end", int'(empty), 1);

        // Randomised operations against the queue model.
        for (int i = 0; i < 300; i++) begin
            k   = int'($urandom_range(0, 11));
            rd8 = 8'($urandom);
            if (k < 5) do_op(OpW, rd8);
            else if (k < 8) do_op(OpR, rd8);
            else if (k < 10) do_op(OpB, rd8);
            else if (k == 10) do_op((rd8[0]) ? OpFW : OpF, rd8);
            else do_op(OpC, rd8);
            check_model($sformatf("rand%0d", i));
        end

        // Reset while a write strobe is high; the strobe commits once after release.
        @(posedge clk);
        wr_req = 1'b1;
        din    = 8'h5C;
        repeat (2) @(posedge clk);
        sys_rst_n = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(posedge clk);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        wr_req = 1'b0;
        repeat (3) @(posedge clk);
        m_q.push_back(8'h5C);
        check_model("rst_mid_strobe");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
